// File: rtl/asp_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : asp_host_tx
// Brief    : Host-side word buffer that adds even parity and launches words
//            to the ASP as one-cycle ready pulses with a minimum idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module asp_host_tx #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_wr_en_in,
    input  logic [DATA_SIZE-1:0] host_data_in,
    input  logic                 parity_inject_in,
    input  logic                 asp_busy_in,
    output logic                 data_parity_ready_out,
    output logic [DATA_SIZE:0]   data_parity_out,
    output logic                 fifo_full_out,
    output logic                 fifo_empty_out,
    output logic                 overflow_out,
    output logic [15:0]          word_count_out
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [DATA_SIZE:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_GW-1:0]    r_gap_cnt;
    logic [DATA_SIZE:0] r_data_parity;
    logic               r_overflow;
    logic [15:0]        r_word_count;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_pop;
    logic [DATA_SIZE:0] w_wr_word;

    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    // Fullness is judged before any same-cycle pop, so a pop never makes room.
    assign w_wr      = host_wr_en_in && !w_full;
    assign w_pop     = (r_state == c_IDLE) && !w_empty && !asp_busy_in;
    assign w_wr_word = {(^host_data_in) ^ parity_inject_in, host_data_in};

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_data_parity <= '0;
            r_word_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + c_AW'(1);
                r_data_parity <= r_mem[r_rd_ptr];
                r_word_count  <= r_word_count + 16'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (host_wr_en_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_SEND) begin
                r_gap_cnt <= c_GW'(GAP_CYCLES);
            end else if (r_state == c_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_GW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pop) begin
                    w_state_next = c_SEND;
                end
            end
            c_SEND: begin
                w_state_next = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;
            end
            c_GAP: begin
                // Counter holds the remaining gap cycles including this one.
                if (r_gap_cnt <= c_GW'(1)) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    assign data_parity_ready_out = (r_state == c_SEND);
    assign data_parity_out       = r_data_parity;
    assign fifo_full_out         = w_full;
    assign fifo_empty_out        = w_empty;
    assign overflow_out          = r_overflow;
    assign word_count_out        = r_word_count;

endmodule
`default_nettype wire
